// File: rtl/telem_pkg.sv
// Shared telemetry link definitions: header bytes, packet length and the packet-layer state
// encoding used by the transmitter, the receiver and the benches.
package telem_pkg;

  localparam logic [7:0]  TELEM_HDR1    = 8'hAA;
  localparam logic [7:0]  TELEM_HDR2    = 8'h55;
  localparam int unsigned TELEM_PKT_LEN = 8;

  typedef enum logic [2:0] {HDR1, HDR2, VH, VL, CH, CL, TH, TL} telem_state_t;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} uart_state_t;

  // High bytes of each 12-bit field carry data only in their low nibble.
  function automatic logic is_hi_byte(telem_state_t s);
    return (s == VH) || (s == CH) || (s == TH);
  endfunction

endpackage

// File: rtl/telemetry_rcv_if.sv
// Serial input and decoded telemetry outputs of the receiver. The master side drives the line
// and observes results; the slave side is the receiver itself.
interface telemetry_rcv_if;

  logic        RX;
  logic [11:0] batt_v;
  logic [11:0] avg_curr;
  logic [11:0] avg_torque;
  logic        pkt_vld;
  logic        pkt_err;

  modport master (
    output RX,
    input  batt_v,
    input  avg_curr,
    input  avg_torque,
    input  pkt_vld,
    input  pkt_err
  );

  modport slave (
    input  RX,
    output batt_v,
    output avg_curr,
    output avg_torque,
    output pkt_vld,
    output pkt_err
  );

endinterface

// File: rtl/telem_uart_rx.sv
// 8N1 byte receiver: synchronises the line, times bit centres from the start edge and
// reports each byte with a one-cycle byte_rdy, or a bad stop bit with frm_err.
module telem_uart_rx
  import telem_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_rdy,
  output logic       frm_err
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] HalfM1 = CntW'(BAUD_DIV / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(BAUD_DIV - 1);

  uart_state_t     state_q;
  logic            rx_meta_q;
  logic            rx_sync_q;
  logic            rx_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RxIdle;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data      <= '0;
      byte_rdy  <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      byte_rdy  <= 1'b0;
      frm_err   <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= RxStart;
            cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (cnt_q == HalfM1) begin
            cnt_q <= '0;
            // A line back high at mid-start was a glitch, not a frame.
            if (rx_sync_q) begin
              state_q <= RxIdle;
            end else begin
              state_q   <= RxData;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == FullM1) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= RxStop;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == FullM1) begin
            cnt_q   <= '0;
            state_q <= RxIdle;
            if (rx_sync_q) begin
              byte_rdy <= 1'b1;
              data     <= shift_q;
            end else begin
              frm_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/telemetry_rcv.sv
// Telemetry link receiver: rebuilds {AA,55,Vh,Vl,Ch,Cl,Th,Tl} packets from the UART byte stream
// and publishes the three 12-bit fields atomically with a pkt_vld strobe.
module telemetry_rcv
  import telem_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned TO_BITS  = 20
) (
  input  logic            clk,
  input  logic            rst,
  telemetry_rcv_if.slave  bus
);

  localparam int unsigned GapLimit = TO_BITS * BAUD_DIV;
  localparam int unsigned GapW     = $clog2(GapLimit + 1);

  logic [1:0]      rst_sync_q;
  logic            rst_int;
  logic [7:0]      rx_byte;
  logic            byte_rdy;
  logic            frm_err;
  logic [GapW-1:0] gap_q;
  logic            timeout;

  telem_state_t state_q;
  logic [3:0]   v_hi_q;
  logic [7:0]   v_lo_q;
  logic [3:0]   c_hi_q;
  logic [7:0]   c_lo_q;
  logic [3:0]   t_hi_q;
  logic [11:0]  batt_v_q;
  logic [11:0]  avg_curr_q;
  logic [11:0]  avg_torque_q;
  logic         pkt_vld_q;
  logic         pkt_err_q;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_q[1];

  telem_uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_rx (
    .clk      (clk),
    .rst      (rst_int),
    .rx       (bus.RX),
    .data     (rx_byte),
    .byte_rdy (byte_rdy),
    .frm_err  (frm_err)
  );

  // Saturating inter-byte gap counter; cleared by every received byte.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      gap_q <= '0;
    end else if (byte_rdy) begin
      gap_q <= '0;
    end else if (gap_q != GapW'(GapLimit)) begin
      gap_q <= gap_q + 1'b1;
    end
  end

  assign timeout = (gap_q == GapW'(GapLimit)) && (state_q != HDR1) && (state_q != HDR2);

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q      <= HDR1;
      v_hi_q       <= '0;
      v_lo_q       <= '0;
      c_hi_q       <= '0;
      c_lo_q       <= '0;
      t_hi_q       <= '0;
      batt_v_q     <= '0;
      avg_curr_q   <= '0;
      avg_torque_q <= '0;
      pkt_vld_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      pkt_vld_q <= 1'b0;
      pkt_err_q <= 1'b0;
      if (byte_rdy) begin
        if (is_hi_byte(state_q) && (rx_byte[7:4] != 4'h0)) begin
          pkt_err_q <= 1'b1;
          state_q   <= HDR1;
        end else begin
          unique case (state_q)
            HDR1: begin
              if (rx_byte == TELEM_HDR1) state_q <= HDR2;
            end
            HDR2: begin
              if (rx_byte == TELEM_HDR2) begin
                state_q <= VH;
              end else if (rx_byte != TELEM_HDR1) begin
                state_q <= HDR1;
              end
            end
            VH: begin
              v_hi_q  <= rx_byte[3:0];
              state_q <= VL;
            end
            VL: begin
              v_lo_q  <= rx_byte;
              state_q <= CH;
            end
            CH: begin
              c_hi_q  <= rx_byte[3:0];
              state_q <= CL;
            end
            CL: begin
              c_lo_q  <= rx_byte;
              state_q <= TH;
            end
            TH: begin
              t_hi_q  <= rx_byte[3:0];
              state_q <= TL;
            end
            TL: begin
              batt_v_q     <= {v_hi_q, v_lo_q};
              avg_curr_q   <= {c_hi_q, c_lo_q};
              avg_torque_q <= {t_hi_q, rx_byte};
              pkt_vld_q    <= 1'b1;
              state_q      <= HDR1;
            end
            default: state_q <= HDR1;
          endcase
        end
      end else if (frm_err || timeout) begin
        // While still hunting for the header a broken frame is not a lost packet.
        pkt_err_q <= (state_q != HDR1) && (state_q != HDR2);
        state_q   <= HDR1;
      end
    end
  end

  assign bus.batt_v     = batt_v_q;
  assign bus.avg_curr   = avg_curr_q;
  assign bus.avg_torque = avg_torque_q;
  assign bus.pkt_vld    = pkt_vld_q;
  assign bus.pkt_err    = pkt_err_q;

endmodule

// File: tb/tb_telemetry_rcv.sv
// Self-checking bench for telemetry_rcv: bit-accurate UART driver, packet-level reference model
// and a per-cycle compare process, with directed scenarios followed by randomized traffic.
module tb_telemetry_rcv;
  import telem_pkg::*;

  localparam int unsigned BD  = 16;
  localparam int unsigned TO  = 20;
  localparam int          LIM = TO * BD;
  localparam int          MAX_LAT = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  telemetry_rcv_if bus ();

  telemetry_rcv #(
    .BAUD_DIV (BD),
    .TO_BITS  (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_err;
    logic [11:0] v;
    logic [11:0] c;
    logic [11:0] t;
    int          push_cyc;
  } ev_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_vld = 0;
  int n_err = 0;
  int last_err_cyc = 0;
  int last_stop_cyc = 0;

  // Reference model: position within the packet, payload bytes, pending expected pulses.
  ev_t         evq[$];
  int          pos = 0;
  int          model_gap = 0;
  logic [7:0]  pl [6];
  logic [11:0] cur_v = '0;
  logic [11:0] cur_c = '0;
  logic [11:0] cur_t = '0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit is_err, input logic [11:0] v, input logic [11:0] c,
                         input logic [11:0] t);
    ev_t e;
    e.is_err   = is_err;
    e.v        = v;
    e.c        = c;
    e.t        = t;
    e.push_cyc = cyc;
    evq.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    int idx;
    model_gap = 0;
    if (pos == 0) begin
      if (b == TELEM_HDR1) pos = 1;
    end else if (pos == 1) begin
      if (b == TELEM_HDR2) pos = 2;
      else if (b != TELEM_HDR1) pos = 0;
    end else begin
      idx = pos - 2;
      if ((idx % 2 == 0) && (b[7:4] != 4'h0)) begin
        push_ev(1'b1, '0, '0, '0);
        pos = 0;
      end else begin
        pl[idx] = b;
        pos++;
        if (pos == TELEM_PKT_LEN) begin
          push_ev(1'b0, {pl[0][3:0], pl[1]}, {pl[2][3:0], pl[3]}, {pl[4][3:0], pl[5]});
          pos = 0;
        end
      end
    end
  endtask

  task automatic model_frm();
    if (pos >= 2) push_ev(1'b1, '0, '0, '0);
    pos = 0;
  endtask

  task automatic model_reset();
    evq.delete();
    pos       = 0;
    model_gap = 0;
    cur_v     = '0;
    cur_c     = '0;
    cur_t     = '0;
  endtask

  // Model-side inter-byte timeout, counted in clocks from the middle of the last stop bit.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (model_gap < LIM) model_gap++;
        if (pos >= 2 && model_gap >= LIM) begin
          push_ev(1'b1, '0, '0, '0);
          pos = 0;
        end
      end
    end
  end

  // Compare process: every cycle, outputs must equal the last good packet; each pulse must
  // match the oldest pending model event within a few clocks.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      chk("vld_err_exclusive", {35'd0, bus.pkt_vld & bus.pkt_err}, 36'd0);
      if (bus.pkt_vld) n_vld++;
      if (bus.pkt_err) begin
        n_err++;
        last_err_cyc = cyc;
      end
      if (bus.pkt_vld || bus.pkt_err) begin
        if (evq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: vld=%0b err=%0b with no event expected (cycle %0d)",
                   bus.pkt_vld, bus.pkt_err, cyc);
        end else begin
          e = evq.pop_front();
          chk("pulse_kind_err", {35'd0, bus.pkt_err}, {35'd0, e.is_err});
          if (!e.is_err) begin
            cur_v = e.v;
            cur_c = e.c;
            cur_t = e.t;
          end
        end
      end
      chk("outputs", {bus.batt_v, bus.avg_curr, bus.avg_torque}, {cur_v, cur_c, cur_t});
      if (evq.size() > 0 && (cyc - evq[0].push_cyc) > MAX_LAT) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse: expected %s not seen within %0d cycles (cycle %0d)",
                 evq[0].is_err ? "pkt_err" : "pkt_vld", MAX_LAT, cyc);
        void'(evq.pop_front());
      end
    end
  end

  // Bit-accurate 8N1 driver; the model is told about the byte at the stop-bit centre.
  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int gap_bits);
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      repeat (BD) @(negedge clk);
    end
    bus.RX = !bad_stop;
    repeat (BD / 2) @(negedge clk);
    last_stop_cyc = cyc;
    if (bad_stop) model_frm();
    else model_byte(b);
    repeat (BD / 2 - 1) @(negedge clk);
    bus.RX = 1'b1;
    if (bad_stop) repeat (BD) @(negedge clk);
    repeat (gap_bits * BD) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int last_gap);
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i], 1'b0, (i == q.size() - 1) ? last_gap : 0);
    end
  endtask

  task automatic settle();
    repeat (3 * BD) @(negedge clk);
  endtask

  initial begin
    logic [7:0] pk[$];
    int v0;
    int e0;
    logic [7:0] b;
    bus.RX = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_outputs", {bus.batt_v, bus.avg_curr, bus.avg_torque}, 36'd0);
    chk("reset_pulses", {34'd0, bus.pkt_vld, bus.pkt_err}, 36'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: basic packet
    v0 = n_vld;
    e0 = n_err;
    pk = {8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};
    send_seq(pk, 1);
    settle();
    chk("t1_vld_count", 36'(n_vld - v0), 36'd1);
    chk("t1_values", {bus.batt_v, bus.avg_curr, bus.avg_torque}, 36'hABC_123_FFF);

    // 2: junk then repeated header
    v0 = n_vld;
    pk = {8'h13, 8'hAA, 8'hAA, 8'h55, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    send_seq(pk, 1);
    settle();
    chk("t2_vld_count", 36'(n_vld - v0), 36'd1);
    chk("t2_no_err", 36'(n_err - e0), 36'd0);
    chk("t2_values", {bus.batt_v, bus.avg_curr, bus.avg_torque}, 36'h001_002_003);

    // 3: bad high nibble
    v0 = n_vld;
    e0 = n_err;
    pk = {8'hAA, 8'h55, 8'h1A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF};
    send_seq(pk, 1);
    settle();
    chk("t3_err_count", 36'(n_err - e0), 36'd1);
    chk("t3_no_vld", 36'(n_vld - v0), 36'd0);
    chk("t3_hold", {bus.batt_v, bus.avg_curr, bus.avg_torque}, 36'h001_002_003);

    // 4: inter-byte timeout, then recovery
    e0 = n_err;
    pk = {8'hAA, 8'h55, 8'h0A, 8'hBC};
    send_seq(pk, 25);
    chk("t4_err_count", 36'(n_err - e0), 36'd1);
    chk("t4_timeout_window",
        {35'd0, (last_err_cyc - last_stop_cyc) >= LIM &&
                (last_err_cyc - last_stop_cyc) <= LIM + MAX_LAT}, 36'd1);
    pk = {8'hAA, 8'h55, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC};
    send_seq(pk, 1);
    settle();
    chk("t4_recover", {bus.batt_v, bus.avg_curr, bus.avg_torque}, 36'h456_789_ABC);

    // 5: framing error on Cl
    e0 = n_err;
    send_byte(8'hAA, 1'b0, 0);
    send_byte(8'h55, 1'b0, 0);
    send_byte(8'h0B, 1'b0, 0);
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h02, 1'b0, 0);
    send_byte(8'h22, 1'b1, 0);
    settle();
    chk("t5_err_count", 36'(n_err - e0), 36'd1);
    pk = {8'hAA, 8'h55, 8'h07, 8'h77, 8'h08, 8'h88, 8'h09, 8'h99};
    send_seq(pk, 1);
    settle();
    chk("t5_recover", {bus.batt_v, bus.avg_curr, bus.avg_torque}, 36'h777_888_999);

    // 6: reset mid-payload
    pk = {8'hAA, 8'h55, 8'h03};
    send_seq(pk, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("t6_reset_zero", {bus.batt_v, bus.avg_curr, bus.avg_torque}, 36'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    pk = {8'hAA, 8'h55, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h01, 8'h02};
    send_seq(pk, 1);
    settle();
    chk("t6_recover", {bus.batt_v, bus.avg_curr, bus.avg_torque}, 36'hC0D_E0F_102);

    // Randomized traffic: junk, back-to-back packets, bad nibbles, framing errors, timeouts.
    for (int p = 0; p < 25; p++) begin
      int njunk;
      njunk = $urandom_range(0, 2);
      pk.delete();
      for (int j = 0; j < njunk; j++) pk.push_back(8'($urandom));
      pk.push_back(TELEM_HDR1);
      pk.push_back(TELEM_HDR2);
      for (int j = 0; j < 6; j++) begin
        b = 8'($urandom);
        if (j % 2 == 0 && $urandom_range(0, 9) != 0) b[7:4] = 4'h0;
        pk.push_back(b);
      end
      for (int j = 0; j < pk.size(); j++) begin
        int gap;
        int r;
        r = $urandom_range(0, 99);
        gap = (r < 3) ? 25 : ((r < 40) ? $urandom_range(0, 4) : 0);
        send_byte(pk[j], ($urandom_range(0, 99) < 3), gap);
      end
    end
    repeat (LIM + 4 * BD) @(negedge clk);
    chk("final_no_pending", 36'(evq.size()), 36'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
